// File: rtl/div3_pkg.sv
// Shared constants and the S2 payload bundle for the divide-by-3 scheduler.
// Optional stats feature is selected by macro DIV3_SCHED_STATS_EN.
package div3_pkg;

  localparam int DIV3_X_W      = 64;
  localparam int DIV3_Q_W      = 63;
  localparam int DIV3_R_W      = 2;
  localparam int DIV3_ID_MAX_W = 3;

  typedef struct packed {
    logic [DIV3_Q_W-1:0]      q;
    logic [DIV3_R_W-1:0]      r;
    logic [DIV3_ID_MAX_W-1:0] id;
  } div3_s2_t;

endpackage

// File: rtl/div_64_3.sv
// Combinational 64-bit divide by constant 3.
// Ports: x (dividend) -> q (quotient, 63b), r (remainder, 0..2).
module div_64_3
  import div3_pkg::*;
(
  input  logic [DIV3_X_W-1:0] x,
  output logic [DIV3_Q_W-1:0] q,
  output logic [DIV3_R_W-1:0] r
);

  assign q = DIV3_Q_W'(x / 64'd3);
  assign r = DIV3_R_W'(x % 64'd3);

endmodule

// File: rtl/div3_rr_sched.sv
// Round-robin scheduler feeding a two-stage divide-by-3 pipeline.
// Ports: clk, rst_n, req_valid/req_x/req_ready (N_REQ requesters),
//   rsp_valid/rsp_ready/rsp_id/rsp_q/rsp_r; with DIV3_SCHED_STATS_EN
//   also stat_issued and stat_stall counters.
module div3_rr_sched
  import div3_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [DIV3_X_W*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DIV3_Q_W-1:0]       rsp_q,
  output logic [DIV3_R_W-1:0]       rsp_r
`ifdef DIV3_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall
`endif
);

  logic                s1_v;
  logic [DIV3_X_W-1:0] s1_x;
  logic [ID_W-1:0]     s1_id;
  logic                s2_v;
  div3_s2_t            s2;
  logic [ID_W-1:0]     ptr;

  logic                s2_adv;
  logic                s1_can;
  logic                any;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     ptr_nxt;
  logic                accept;
  logic [DIV3_X_W-1:0] win_x;
  logic [DIV3_Q_W-1:0] dq;
  logic [DIV3_R_W-1:0] dr;
  int                  idx;

  assign s2_adv = !s2_v || rsp_ready;
  assign s1_can = !s1_v || s2_adv;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;

  // Gate with rst_n so no grant is shown while reset is held.
  assign accept = any && s1_can && rst_n;

  assign req_ready = accept ? (N_REQ'(1) << win) : '0;

  assign win_x = req_x[int'(win)*DIV3_X_W +: DIV3_X_W];

  div_64_3 u_div (
    .x (s1_x),
    .q (dq),
    .r (dr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_x  <= '0;
      s1_id <= '0;
      s2_v  <= 1'b0;
      s2    <= '0;
      ptr   <= '0;
    end else begin
      // S1 reloads whenever it can accept; a bubble clears s1_v.
      if (s1_can) begin
        s1_v <= any;
        if (any) begin
          s1_x  <= win_x;
          s1_id <= win;
          ptr   <= ptr_nxt;
        end
      end
      if (s2_adv) begin
        s2_v    <= s1_v;
        s2.q    <= dq;
        s2.r    <= dr;
        s2.id   <= DIV3_ID_MAX_W'(s1_id);
      end
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_q     = s2.q;
  assign rsp_r     = s2.r;
  assign rsp_id    = ID_W'(s2.id);

`ifdef DIV3_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept)
        stat_issued <= stat_issued + 32'd1;
      if (s2_v && !rsp_ready)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div3_rr_sched.sv
// Directed, table-driven bench for div3_rr_sched (4 requesters).
// Optional stats checks compile when DIV3_SCHED_STATS_EN is defined.
module tb_div3_rr_sched;

  localparam logic [62:0] QM = 63'h5555555555555555;

  typedef struct {
    logic [3:0]  rv;
    logic        rdy;
    logic [3:0]  ready;
    logic        v;
    logic [1:0]  id;
    logic [62:0] q;
    logic [1:0]  r;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [255:0] req_x;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [62:0]  rsp_q;
  logic [1:0]   rsp_r;
`ifdef DIV3_SCHED_STATS_EN
  logic [31:0]  stat_issued;
  logic [31:0]  stat_stall;
`endif

  logic [63:0] xl [4];
  int errors = 0;
  int checks = 0;

  assign req_x = {xl[3], xl[2], xl[1], xl[0]};

  always #5 clk = ~clk;

  div3_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r)
`ifdef DIV3_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rv, input logic rdy,
                              input logic [3:0] ready, input logic v,
                              input logic [1:0] id, input logic [62:0] q,
                              input logic [1:0] r);
    vec_t t;
    t.rv = rv; t.rdy = rdy; t.ready = ready;
    t.v = v; t.id = id; t.q = q; t.r = r;
    return t;
  endfunction

  // Drive one cycle, check what is visible before the edge, then clock.
  task automatic apply(input string nm, input vec_t t);
    req_valid = t.rv;
    rsp_ready = t.rdy;
    #1;
    check({nm, ".ready"}, 64'(req_ready), 64'(t.ready));
    check({nm, ".v"}, 64'(rsp_valid), 64'(t.v));
    if (t.v) begin
      check({nm, ".id"}, 64'(rsp_id), 64'(t.id));
      check({nm, ".q"}, 64'(rsp_q), 64'(t.q));
      check({nm, ".r"}, 64'(rsp_r), 64'(t.r));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [18];

  initial begin
    xl[0] = 64'd100;
    xl[1] = 64'd7;
    xl[2] = 64'd10;
    xl[3] = '1;

    // round robin from reset, lone requester, stall with release
    tbl[0]  = mk(4'b1111, 1, 4'b0001, 0, 0, 0, 0);
    tbl[1]  = mk(4'b1111, 1, 4'b0010, 0, 0, 0, 0);
    tbl[2]  = mk(4'b1111, 1, 4'b0100, 1, 0, 63'd33, 1);
    tbl[3]  = mk(4'b1111, 1, 4'b1000, 1, 1, 63'd2, 1);
    tbl[4]  = mk(4'b1111, 1, 4'b0001, 1, 2, 63'd3, 1);
    tbl[5]  = mk(4'b0000, 1, 4'b0000, 1, 3, QM, 0);
    tbl[6]  = mk(4'b0100, 1, 4'b0100, 1, 0, 63'd33, 1);
    tbl[7]  = mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    tbl[8]  = mk(4'b0000, 1, 4'b0000, 1, 2, 63'd3, 1);
    tbl[9]  = mk(4'b1111, 0, 4'b1000, 0, 0, 0, 0);
    tbl[10] = mk(4'b1111, 0, 4'b0001, 0, 0, 0, 0);
    tbl[11] = mk(4'b1111, 0, 4'b0000, 1, 3, QM, 0);
    tbl[12] = mk(4'b1111, 0, 4'b0000, 1, 3, QM, 0);
    tbl[13] = mk(4'b1111, 0, 4'b0000, 1, 3, QM, 0);
    tbl[14] = mk(4'b1111, 1, 4'b0010, 1, 3, QM, 0);
    tbl[15] = mk(4'b0000, 1, 4'b0000, 1, 0, 63'd33, 1);
    tbl[16] = mk(4'b0000, 1, 4'b0000, 1, 1, 63'd2, 1);
    tbl[17] = mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0);

    // reset state, with requests pending
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 64'(req_ready), 64'd0);
    check("rst.v", 64'(rsp_valid), 64'd0);
    check("rst.q", 64'(rsp_q), 64'd0);
    check("rst.r", 64'(rsp_r), 64'd0);
    check("rst.id", 64'(rsp_id), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      apply($sformatf("tbl%0d", i), tbl[i]);

    // small dividends: X=2 and X=0, ptr currently 2
    xl[0] = 64'd2;
    xl[1] = 64'd0;
    apply("sm0", mk(4'b0011, 1, 4'b0001, 0, 0, 0, 0));
    apply("sm1", mk(4'b0011, 1, 4'b0010, 0, 0, 0, 0));
    apply("sm2", mk(4'b0000, 1, 4'b0000, 1, 0, 63'd0, 2));
    apply("sm3", mk(4'b0000, 1, 4'b0000, 1, 1, 63'd0, 0));

    // reset while two requests are in flight
    apply("mr0", mk(4'b1111, 0, 4'b0100, 0, 0, 0, 0));
    apply("mr1", mk(4'b1111, 0, 4'b1000, 0, 0, 0, 0));
    apply("mr2", mk(4'b1111, 0, 4'b0000, 1, 2, 63'd3, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mr.v", 64'(rsp_valid), 64'd0);
    check("mr.ready", 64'(req_ready), 64'd0);
    check("mr.q", 64'(rsp_q), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply("mr3", mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    apply("mr4", mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    apply("mr5", mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    apply("mr6", mk(4'b1111, 1, 4'b0001, 0, 0, 0, 0));

`ifdef DIV3_SCHED_STATS_EN
    rst_n = 1'b0;
    #1;
    check("st.rst_iss", 64'(stat_issued), 64'd0);
    check("st.rst_stl", 64'(stat_stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] e;
      e = 4'b0001 << (k % 4);
      #1;
      check($sformatf("st.gnt%0d", k), 64'(req_ready), 64'(e));
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("st.issued", 64'(stat_issued), 64'd10);
    check("st.stall", 64'(stat_stall), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div3_rr_sched.md
DIV3_RR_SCHED -- requirements
Module: div3_rr_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ID_W, default 2, requester-ID width, equal to clog2(N_REQ).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester request valid.
REQ-006 SHALL have port req_x, input, 64*N_REQ, dividend of requester i at bits [64*i+63:64*i].
REQ-007 SHALL have port req_ready, output, N_REQ, one-hot grant/accept.
REQ-008 SHALL have port rsp_valid, output, 1, result valid.
REQ-009 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port rsp_id, output, ID_W, index of the originating requester.
REQ-011 SHALL have port rsp_q, output, 63, quotient floor(X/3).
REQ-012 SHALL have port rsp_r, output, 2, remainder X mod 3 (0..2).

Function
REQ-013 SHALL form a two-stage pipeline: S1 registers (x, id, v); S1 output drives the divider; S2 registers (q, r, id, v) drive the rsp_* outputs.
REQ-014 SHALL advance S2 when !S2.v or rsp_ready; SHALL advance S1 into S2 under the same condition.
REQ-015 SHALL accept a request into S1 only when !S1.v or S1 advances in the same cycle.
REQ-016 SHALL grant round-robin: search starts at pointer ptr, and the first i with req_valid[i] at or after ptr (mod N_REQ) wins.
REQ-017 SHALL drive req_ready combinationally (valid-to-ready path allowed): at most one bit set, only for the winner, only when S1 can accept; all zero otherwise.
REQ-018 SHALL set ptr to (winner+1) mod N_REQ on each accepted transfer; ptr wraps from N_REQ-1 to 0; ptr holds when nothing is accepted.
REQ-019 SHALL produce a result 2 cycles after acceptance when rsp_ready is held high (accept at edge n, rsp_valid from edge n+2).
REQ-020 SHALL sustain one accepted request per cycle with rsp_ready high; SHALL hold at most 2 requests in flight.
REQ-021 SHALL keep rsp_q, rsp_r, rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL deliver responses in acceptance order, with no loss and no duplication.
REQ-023 SHALL allow a same-cycle S2 drain, S1 shift, and new accept, with no bubble.
REQ-024 SHALL not grant any requester when req_valid is all zero; S1.v then clears on the next advance.

Reset
REQ-025 SHALL asynchronously clear S1.v, S2.v, ptr (to 0), and all data registers (to 0) on rst_n=0; outputs are then rsp_valid=0, rsp_q=0, rsp_r=0, rsp_id=0, req_ready=0.
REQ-026 SHALL discard in-flight requests when reset asserts mid-operation; no response is issued for them after release.
REQ-027 SHALL permit the first grant on the first clock edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro DIV3_SCHED_STATS_EN defined, add output ports stat_issued (32 bits, accepted requests) and stat_stall (32 bits, cycles with rsp_valid=1 and rsp_ready=0); both are reset to 0 and wrap modulo 2^32.
REQ-029 SHALL, without DIV3_SCHED_STATS_EN, omit those ports and counters, with all other behaviour identical.

Structure
REQ-030 SHALL place the constants DIV3_X_W=64, DIV3_Q_W=63, DIV3_R_W=2 and the S2 payload typedef (q, r, id) in the shared package div3_pkg.
REQ-031 SHALL instantiate exactly one existing combinational divider div_64_3 (X 64 bits -> Q 63 bits, R 2 bits) between S1 and S2; arbitration logic stays inline.

Verification
REQ-032 SHALL cover: only req 2 valid, X=10, rsp_ready=1 -> req_ready=4'b0100; two cycles later rsp_valid=1, rsp_id=2, rsp_q=3, rsp_r=1.
REQ-033 SHALL cover: X=2^64-1 -> rsp_q=0x5555555555555555, rsp_r=0; X=2 -> rsp_q=0, rsp_r=2; X=0 -> rsp_q=0, rsp_r=0.
REQ-034 SHALL cover: all 4 requesters valid continuously after reset, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; rsp_id follows the same order with 2-cycle lag.
REQ-035 SHALL cover: rsp_ready=0 for 5 cycles with all requests valid -> exactly 2 accepts, then req_ready=0; outputs stable; on release, responses arrive in order with no loss.
REQ-036 SHALL cover: rst_n pulsed low while 2 requests are in flight -> rsp_valid=0 immediately; no stale response after release; ptr=0, so requester 0 wins first.
REQ-037 SHALL cover, with DIV3_SCHED_STATS_EN: 10 accepts and 3 stalled cycles -> stat_issued=10, stat_stall=3.
